arb_rr_pry: RTL and testbench
=============================

ARB_RR_PRY -- requirements
Module: arb_rr_pry

Interface
REQ-001 Parameter: WIDTH, 8, number of requesters; the block SHALL support any WIDTH >= 2.
REQ-002 Parameter: DIRECTION, "LSB", rotation direction.
- "LSB": search from bit 0 upward.
- "MSB": search from bit WIDTH-1 downward.
REQ-003 Parameter: IMPLEMENTATION, 0, selects the priority-to-thermometer encoder implementation; it SHALL NOT change the cycle-level behaviour.
REQ-004 Port: clk, input, 1, single clock; all state SHALL be updated on its rising edge.
REQ-005 Port: rst, input, 1, synchronous active-high reset.
REQ-006 Port: req, input, WIDTH, per-requester request; bit i high means requester i has a pending transaction.
REQ-007 Port: ack, input, 1, downstream accepts the current grant in this cycle.
REQ-008 Port: grt, output, WIDTH, registered grant; one-hot when vld=1, all zero when vld=0.
REQ-009 Port: idx, output, $clog2(WIDTH), binary index of the granted bit; 0 when vld=0.
REQ-010 Port: vld, output, 1, grant valid; the handshake completes when vld&ack.

Function
REQ-011 The block SHALL have two states, IDLE (vld=0) and BUSY (vld=1), held in registers.
REQ-012 The block SHALL keep a WIDTH-bit thermometer mask register msk.
REQ-013 Arbitration SHALL work as follows:
- cand = req & msk.
- If cand != 0, the winner SHALL be the first set bit of cand in DIRECTION order.
- Otherwise the winner SHALL be the first set bit of req in DIRECTION order (wrap-around).
REQ-014 IDLE with req != 0: the block SHALL register the winner into grt/idx, set vld=1 and go to BUSY, giving a latency of 1 cycle from req to vld.
REQ-015 IDLE with req == 0: the block SHALL stay in IDLE with grt=0, idx=0, vld=0, and msk SHALL be unchanged.
REQ-016 BUSY with ack=0: grt, idx, vld and msk SHALL hold their values, including when the granted requester's req bit drops (the grant is not revoked).
REQ-017 BUSY with ack=1 and winner index g: msk SHALL be loaded as follows.
- "LSB": bits strictly above g set, others clear.
- "MSB": bits strictly below g set, others clear.
REQ-018 BUSY with ack=1: the block SHALL re-arbitrate in the same cycle, using the req sampled in that cycle (granted bit included) and the newly computed msk.
- If req != 0: the next grant SHALL be registered and the block SHALL stay in BUSY, giving back-to-back grants at 1 grant/cycle.
- If req == 0: the block SHALL go to IDLE, with grt=0 and vld=0 the next cycle.
REQ-019 A single requester that holds req high with ack=1 every cycle SHALL be granted every cycle, through wrap-around.
REQ-020 Fairness: with all requests held, any requester SHALL be granted within WIDTH accepted grants of the previous acceptance.
REQ-021 ack while in IDLE SHALL be ignored.
REQ-022 grt SHALL never have more than one bit set, and idx SHALL always equal the binary encoding of grt.
REQ-023 Winner selection SHALL be built from priority-to-thermometer conversion on req & msk and on req, with the one-hot derived as thr & ~(thr shifted by one toward the search direction).

Reset
REQ-024 When rst=1 at a clock edge, the block SHALL set state=IDLE, grt=0, idx=0, vld=0 and msk=all ones.
REQ-025 Reset SHALL take priority over every other input; a grant pending mid-handshake SHALL be dropped without updating msk.
REQ-026 After rst is released, the first grant SHALL go to the lowest-indexed active requester ("LSB") or the highest-indexed one ("MSB").

Verification
REQ-027 The bench SHALL cover the following directed scenarios (WIDTH=4, "LSB" unless stated):
- Full rotation: req=1111, ack=1 constantly, starting after reset -> grt sequence 0001,0010,0100,1000,0001 on consecutive cycles, with vld=1 from cycle 1.
- Stall: req=0110, ack=0 for 3 cycles then 1 -> grt=0010 held for 4 cycles, then grt=0100.
- Wrap with sparse requests: grant at idx=3 accepted, then req=0101 -> next grt=0001; after that is accepted, the following grant is grt=0100.
- Single requester: req=0100, ack=1 -> grt=0100 every cycle.
- Drain to IDLE: req drops to 0000 in the ack cycle -> next cycle vld=0, grt=0000, idx=0.
- Reset mid-handshake: vld=1, grt=0100, rst=1 -> next cycle vld=0; after release with req=1111 -> grt=0001.
- MSB direction: req=1111, ack=1 -> grt sequence 1000,0100,0010,0001,1000.
REQ-028 The bench SHALL check continuously, under random req/ack, that grt is one-hot or zero, that idx matches grt, that the grant is stable while vld&!ack, and that the fairness bound of REQ-020 holds.

Source files
------------

// File: rtl/arb_rr_pry.sv
// rtl/arb_rr_pry.sv - round-robin arbiter with registered one-hot grant and valid/ack handshake
module arb_rr_pry #(
  parameter int WIDTH          = 8,
  parameter     DIRECTION      = "LSB",
  parameter int IMPLEMENTATION = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         req,
  input  logic                     ack,
  output logic [WIDTH-1:0]         grt,
  output logic [$clog2(WIDTH)-1:0] idx,
  output logic                     vld
);

  localparam int IW     = $clog2(WIDTH);
  localparam bit SRCH_MSB = (DIRECTION == "MSB");

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] msk, msk_nx, msk_eff;
  logic [WIDTH-1:0] grt_nx, cand, win;
  logic [IW-1:0]    idx_nx;

  function automatic logic [WIDTH-1:0] rev(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = x[WIDTH-1-i];
    return r;
  endfunction

  // Sets every bit at and above the lowest set bit of x.
  function automatic logic [WIDTH-1:0] thermo_up(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] t;
    if (IMPLEMENTATION == 0) begin
      t[0] = x[0];
      for (int i = 1; i < WIDTH; i++) t[i] = t[i-1] | x[i];
    end else begin
      t = x | (~x + WIDTH'(1));
    end
    return t;
  endfunction

  function automatic logic [WIDTH-1:0] thermo(input logic [WIDTH-1:0] x);
    return SRCH_MSB ? rev(thermo_up(rev(x))) : thermo_up(x);
  endfunction

  function automatic logic [WIDTH-1:0] first(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] t;
    t = thermo(x);
    return SRCH_MSB ? (t & ~(t >> 1)) : (t & ~(t << 1));
  endfunction

  function automatic logic [IW-1:0] enc(input logic [WIDTH-1:0] oh);
    logic [IW-1:0] e;
    e = '0;
    for (int i = 0; i < WIDTH; i++) if (oh[i]) e = e | IW'(i);
    return e;
  endfunction

  always_comb begin
    state_nx = state;
    grt_nx   = grt;
    idx_nx   = idx;
    msk_nx   = msk;
    // On acceptance the mask excludes the winner and everything already passed.
    msk_eff  = (state == BUSY && ack) ? (thermo(grt) & ~grt) : msk;
    cand     = req & msk_eff;
    win      = (|cand) ? first(cand) : first(req);
    case (state)
      IDLE: begin
        if (|req) begin
          grt_nx   = win;
          idx_nx   = enc(win);
          state_nx = BUSY;
        end else begin
          grt_nx = '0;
          idx_nx = '0;
        end
      end
      BUSY: begin
        if (ack) begin
          msk_nx = msk_eff;
          if (|req) begin
            grt_nx = win;
            idx_nx = enc(win);
          end else begin
            grt_nx   = '0;
            idx_nx   = '0;
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grt   <= '0;
      idx   <= '0;
      msk   <= '1;
    end else begin
      state <= state_nx;
      grt   <= grt_nx;
      idx   <= idx_nx;
      msk   <= msk_nx;
    end
  end

  assign vld = (state == BUSY);

endmodule

// File: tb/tb_arb_rr_pry.sv
// tb/tb_arb_rr_pry.sv - directed and random checks of arb_rr_pry at WIDTH=4, both directions
module tb_arb_rr_pry;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0, req_m = '0;
  logic       ack = 1'b0, ack_m = 1'b0;
  logic [3:0] grt, grt_m;
  logic [1:0] idx, idx_m;
  logic       vld, vld_m;

  int checks   = 0;
  int failures = 0;

  arb_rr_pry #(.WIDTH(4), .DIRECTION("LSB"), .IMPLEMENTATION(0)) u_lsb (
    .clk(clk), .rst(rst), .req(req), .ack(ack), .grt(grt), .idx(idx), .vld(vld)
  );

  arb_rr_pry #(.WIDTH(4), .DIRECTION("MSB"), .IMPLEMENTATION(1)) u_msb (
    .clk(clk), .rst(rst), .req(req_m), .ack(ack_m), .grt(grt_m), .idx(idx_m), .vld(vld_m)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_grant(input string tag, input logic [3:0] g, input logic [1:0] i);
    check({tag, "_vld"}, 32'(vld), 32'd1);
    check({tag, "_grt"}, 32'(grt), 32'(g));
    check({tag, "_idx"}, 32'(idx), 32'(i));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    ack = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Invariant, stability and fairness monitor on the LSB instance.
  logic       stall_armed = 1'b0;
  logic [3:0] prev_grt    = '0;
  logic [1:0] prev_idx    = '0;
  int         wait_cnt [4];

  always @(negedge clk) begin
    logic [1:0] e_idx;
    e_idx = '0;
    for (int i = 0; i < 4; i++) if (grt[i]) e_idx = e_idx | 2'(i);
    check("mon_onehot", 32'($countones(grt)), vld ? 32'd1 : 32'd0);
    check("mon_idx", 32'(idx), 32'(e_idx));
    if (stall_armed) begin
      check("mon_hold_grt", 32'(grt), 32'(prev_grt));
      check("mon_hold_idx", 32'(idx), 32'(prev_idx));
    end
    stall_armed = vld && !ack && !rst;
    prev_grt    = grt;
    prev_idx    = idx;
    if (rst) begin
      for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!req[i]) wait_cnt[i] = 0;
        else if (vld && ack) begin
          if (grt[i]) wait_cnt[i] = 0;
          else wait_cnt[i]++;
          check("mon_fair", 32'(wait_cnt[i] < 4), 32'd1);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;

    // reset state
    do_reset();
    check("rst_vld", 32'(vld), 32'd0);
    check("rst_grt", 32'(grt), 32'd0);
    check("rst_idx", 32'(idx), 32'd0);
    check("rst_vld_m", 32'(vld_m), 32'd0);

    // full rotation, LSB and MSB side by side
    req = 4'b1111; ack = 1'b1; req_m = 4'b1111; ack_m = 1'b1;
    tick(); expect_grant("rot0", 4'b0001, 2'd0); check("msb0", 32'(grt_m), 32'h8);
    tick(); expect_grant("rot1", 4'b0010, 2'd1); check("msb1", 32'(grt_m), 32'h4);
    tick(); expect_grant("rot2", 4'b0100, 2'd2); check("msb2", 32'(grt_m), 32'h2);
    tick(); expect_grant("rot3", 4'b1000, 2'd3); check("msb3", 32'(grt_m), 32'h1);
    tick(); expect_grant("rot4", 4'b0001, 2'd0); check("msb4", 32'(grt_m), 32'h8);
    check("msb4_idx", 32'(idx_m), 32'd3);
    check("msb4_vld", 32'(vld_m), 32'd1);
    req_m = '0; ack_m = 1'b0;

    // stall then accept
    do_reset();
    req = 4'b0110; ack = 1'b0;
    tick(); expect_grant("stall1", 4'b0010, 2'd1);
    tick(); expect_grant("stall2", 4'b0010, 2'd1);
    req = 4'b0100;
    tick(); expect_grant("stall3", 4'b0010, 2'd1);
    req = 4'b0110; ack = 1'b1;
    tick(); expect_grant("stall_next", 4'b0100, 2'd2);

    // wrap with sparse requests
    do_reset();
    req = 4'b1000; ack = 1'b0;
    tick(); expect_grant("wrap_a", 4'b1000, 2'd3);
    req = 4'b0101; ack = 1'b1;
    tick(); expect_grant("wrap_b", 4'b0001, 2'd0);
    tick(); expect_grant("wrap_c", 4'b0100, 2'd2);

    // single requester
    do_reset();
    req = 4'b0100; ack = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick(); expect_grant("single", 4'b0100, 2'd2);
    end

    // drain to idle, ack in idle ignored
    do_reset();
    req = 4'b0011; ack = 1'b1;
    tick(); expect_grant("drain_a", 4'b0001, 2'd0);
    req = 4'b0000;
    tick();
    check("drain_vld", 32'(vld), 32'd0);
    check("drain_grt", 32'(grt), 32'd0);
    check("drain_idx", 32'(idx), 32'd0);
    tick();
    check("idle_ack_vld", 32'(vld), 32'd0);
    req = 4'b0011;
    tick(); expect_grant("drain_resume", 4'b0010, 2'd1);

    // reset mid-handshake
    do_reset();
    req = 4'b0100; ack = 1'b0;
    tick(); expect_grant("rmid_a", 4'b0100, 2'd2);
    rst = 1'b1; ack = 1'b1;
    tick();
    check("rmid_vld", 32'(vld), 32'd0);
    check("rmid_grt", 32'(grt), 32'd0);
    rst = 1'b0; req = 4'b1111; ack = 1'b0;
    tick(); expect_grant("rmid_b", 4'b0001, 2'd0);

    // random traffic under the monitor
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req = 4'($urandom) | 4'($urandom);
      ack = 1'($urandom);
      tick();
    end
    req = 4'b1111;
    for (int c = 0; c < 200; c++) begin
      ack = 1'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
